// File: rtl/out_channel_pkg.sv
// Shared types for the out-channel checker and its FIFO.
package out_channel_pkg;

  localparam int unsigned DefaultWordWidth = 12;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef logic [DefaultWordWidth-1:0] word_t;

endpackage

// File: rtl/out_channel_checker_if.sv
// Out-channel valid/ready handshake between the executing program and the checker.
interface out_channel_checker_if #(
  parameter int unsigned Width = out_channel_pkg::DefaultWordWidth
) ();

  logic             out_valid;
  logic [Width-1:0] out_data;
  logic             out_ready;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/channel_fifo.sv
// Synchronous FIFO with wrap-bit pointers; pushing into an empty FIFO never bypasses to rdata.
module channel_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  // Same address bits with differing wrap bits means the write pointer lapped the read pointer.
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/out_channel_checker.sv
// Buffers out-channel words and checks them in order against a preloaded expected sequence.
module out_channel_checker
  import out_channel_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = DefaultWordWidth,
  parameter int unsigned NExpect            = 16,
  parameter int unsigned FifoDepth          = 4,
  localparam int unsigned AddrW             = $clog2(NExpect),
  localparam int unsigned CntW              = $clog2(NExpect + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          exp_we,
  input  logic [AddrW-1:0]              exp_addr,
  input  logic [MemoryElementWidth-1:0] exp_data,
  input  logic [CntW-1:0]               exp_count,
  input  logic                          start,
  out_channel_checker_if.slave          out_ch,
  input  logic                          program_finished,
  output logic                          finished,
  output logic                          success,
  output logic [MemoryElementWidth-1:0] mismatches,
  output logic [MemoryElementWidth-1:0] received,
  output logic [CntW-1:0]               first_bad
);

  localparam logic [CntW-1:0]               NExpectC = CntW'(NExpect);
  localparam logic [MemoryElementWidth-1:0] SatMax   = '1;

  logic [MemoryElementWidth-1:0] mem_q [NExpect];

  state_e                        state_q, state_d;
  logic [CntW-1:0]               count_q, count_d;
  logic [CntW-1:0]               idx_q, idx_d;
  logic [CntW-1:0]               first_bad_q, first_bad_d;
  logic [MemoryElementWidth-1:0] mism_q, mism_d;
  logic [MemoryElementWidth-1:0] recv_q, recv_d;

  logic                          fifo_full;
  logic                          fifo_empty;
  logic [MemoryElementWidth-1:0] fifo_rdata;
  logic                          accept;
  logic                          checking;
  logic                          pop;
  logic                          in_range;
  logic                          word_bad;

  assign out_ch.out_ready = (state_q == StRun) && !fifo_full;
  assign accept           = out_ch.out_valid && out_ch.out_ready;
  assign checking         = (state_q == StRun) || (state_q == StDrain);
  assign pop              = checking && !fifo_empty;

  // Words beyond the latched count are surplus and always count as bad.
  assign in_range = (idx_q < count_q);
  assign word_bad = !in_range || (fifo_rdata != mem_q[idx_q[AddrW-1:0]]);

  channel_fifo #(
    .Width (MemoryElementWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i (out_ch.out_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    first_bad_d = first_bad_q;
    mism_d      = mism_q;
    recv_d      = recv_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          count_d     = (exp_count > NExpectC) ? NExpectC : exp_count;
          idx_d       = '0;
          first_bad_d = NExpectC;
          mism_d      = '0;
          recv_d      = '0;
        end
      end
      StRun: begin
        if (program_finished) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (accept && (recv_q != SatMax)) recv_d = recv_q + MemoryElementWidth'(1);

    if (pop) begin
      if (word_bad) begin
        if (mism_q != SatMax)        mism_d      = mism_q + MemoryElementWidth'(1);
        if (first_bad_q == NExpectC) first_bad_d = idx_q;
      end
      if (idx_q != NExpectC) idx_d = idx_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      idx_q       <= '0;
      first_bad_q <= NExpectC;
      mism_q      <= '0;
      recv_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      first_bad_q <= first_bad_d;
      mism_q      <= mism_d;
      recv_q      <= recv_d;
    end
  end

  // Expected memory is deliberately left out of reset so it survives a mid-run abort.
  always_ff @(posedge clock) begin
    if ((state_q == StIdle) && exp_we && (32'(exp_addr) < NExpect)) begin
      mem_q[exp_addr] <= exp_data;
    end
  end

  assign finished   = (state_q == StDone);
  assign success    = finished && (mism_q == '0) && (32'(recv_q) == 32'(count_q));
  assign mismatches = mism_q;
  assign received   = recv_q;
  assign first_bad  = first_bad_q;

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed vector table plus hand sequences for reset, re-arm, drain and FIFO corners.
module tb_out_channel_checker;
  import out_channel_pkg::*;

  localparam int unsigned W  = 12;
  localparam int unsigned NE = 16;
  localparam int unsigned FD = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [W-1:0]  exp_data;
  logic [CW-1:0] exp_count;
  logic          start;
  logic          program_finished;
  logic          finished;
  logic          success;
  logic [W-1:0]  mismatches;
  logic [W-1:0]  received;
  logic [CW-1:0] first_bad;

  logic  f_push, f_pop, f_full, f_empty;
  word_t f_wdata, f_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  out_channel_checker_if #(.Width(W)) ch ();

  out_channel_checker #(
    .MemoryElementWidth (W),
    .NExpect            (NE),
    .FifoDepth          (FD)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .exp_we           (exp_we),
    .exp_addr         (exp_addr),
    .exp_data         (exp_data),
    .exp_count        (exp_count),
    .start            (start),
    .out_ch           (ch),
    .program_finished (program_finished),
    .finished         (finished),
    .success          (success),
    .mismatches       (mismatches),
    .received         (received),
    .first_bad        (first_bad)
  );

  channel_fifo #(
    .Width (W),
    .Depth (FD)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .wdata_i (f_wdata),
    .rdata_o (f_rdata),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    string             name;
    int                n_load;
    logic [7:0][W-1:0] load;
    int                count;
    int                n_send;
    logic [7:0][W-1:0] send;
    int                exp_success;
    int                exp_received;
    int                exp_mism;
    int                exp_first_bad;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0][W-1:0] w8(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7);
    logic [7:0][W-1:0] r;
    r[0] = W'(a0); r[1] = W'(a1); r[2] = W'(a2); r[3] = W'(a3);
    r[4] = W'(a4); r[5] = W'(a5); r[6] = W'(a6); r[7] = W'(a7);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_count = '0;
    start = 1'b0; program_finished = 1'b0; ch.out_valid = 1'b0; ch.out_data = '0;
    f_push = 1'b0; f_pop = 1'b0; f_wdata = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_word(input int addr, input int data);
    exp_we = 1'b1; exp_addr = AW'(addr); exp_data = W'(data);
    tick();
    exp_we = 1'b0;
  endtask

  task automatic pulse_start(input int count);
    exp_count = CW'(count); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Holds out_valid until the checker takes the word; valid stays high across back-to-back calls.
  task automatic send_word(input int data, input logic pf);
    int n = 0;
    ch.out_valid = 1'b1; ch.out_data = W'(data); program_finished = pf;
    while (!ch.out_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready timeout", int'(ch.out_ready), 1);
    tick();
    ch.out_valid = 1'b0; program_finished = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!finished && n < 50) begin
      tick();
      n++;
    end
    check({name, " finished"}, int'(finished), 1);
  endtask

  task automatic set_vec(input int i, input string name, input int n_load,
                         input logic [7:0][W-1:0] load, input int count, input int n_send,
                         input logic [7:0][W-1:0] send, input int succ, input int recv,
                         input int mism, input int fb);
    vecs[i].name = name; vecs[i].n_load = n_load; vecs[i].load = load;
    vecs[i].count = count; vecs[i].n_send = n_send; vecs[i].send = send;
    vecs[i].exp_success = succ; vecs[i].exp_received = recv;
    vecs[i].exp_mism = mism; vecs[i].exp_first_bad = fb;
  endtask

  task automatic run_vec(input int i);
    do_reset();
    for (int k = 0; k < vecs[i].n_load; k++) load_word(k, int'(vecs[i].load[k]));
    pulse_start(vecs[i].count);
    for (int k = 0; k < vecs[i].n_send; k++) send_word(int'(vecs[i].send[k]), 1'b0);
    program_finished = 1'b1;
    tick();
    program_finished = 1'b0;
    wait_done(vecs[i].name);
    check({vecs[i].name, " success"}, int'(success), vecs[i].exp_success);
    check({vecs[i].name, " received"}, int'(received), vecs[i].exp_received);
    check({vecs[i].name, " mismatches"}, int'(mismatches), vecs[i].exp_mism);
    check({vecs[i].name, " first_bad"}, int'(first_bad), vecs[i].exp_first_bad);
  endtask

  initial begin
    set_vec(0, "exact", 5, w8(1, 2, 1, 1, 2, 0, 0, 0), 5, 5, w8(1, 2, 1, 1, 2, 0, 0, 0),
            1, 5, 0, 16);
    set_vec(1, "one_bad", 5, w8(1, 2, 1, 1, 2, 0, 0, 0), 5, 5, w8(1, 2, 3, 1, 2, 0, 0, 0),
            0, 5, 1, 2);
    set_vec(2, "short", 5, w8(1, 2, 1, 1, 2, 0, 0, 0), 5, 3, w8(1, 2, 1, 0, 0, 0, 0, 0),
            0, 3, 0, 16);
    set_vec(3, "surplus", 2, w8(7, 7, 0, 0, 0, 0, 0, 0), 2, 3, w8(7, 7, 9, 0, 0, 0, 0, 0),
            0, 3, 1, 2);
    set_vec(4, "zero_empty", 0, w8(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, w8(0, 0, 0, 0, 0, 0, 0, 0),
            1, 0, 0, 16);
    set_vec(5, "zero_extra", 0, w8(0, 0, 0, 0, 0, 0, 0, 0), 0, 1, w8(4, 0, 0, 0, 0, 0, 0, 0),
            0, 1, 1, 0);
    set_vec(6, "two_bad", 5, w8(1, 2, 3, 4, 5, 0, 0, 0), 5, 5, w8(9, 2, 9, 4, 5, 0, 0, 0),
            0, 5, 2, 0);
    set_vec(7, "burst6", 6, w8(10, 11, 12, 13, 14, 15, 0, 0), 6, 6,
            w8(10, 11, 12, 13, 14, 15, 0, 0), 1, 6, 0, 16);

    // Reset state
    do_reset();
    check("rst finished", int'(finished), 0);
    check("rst success", int'(success), 0);
    check("rst received", int'(received), 0);
    check("rst mismatches", int'(mismatches), 0);
    check("rst first_bad", int'(first_bad), 16);
    check("rst out_ready", int'(ch.out_ready), 0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Abort mid-run, then reload and finish on the same cycle as the last handshake.
    do_reset();
    load_word(0, 1);
    load_word(1, 2);
    pulse_start(2);
    send_word(1, 1'b0);
    send_word(2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort out_ready", int'(ch.out_ready), 0);
    check("abort received", int'(received), 0);
    check("abort first_bad", int'(first_bad), 16);
    load_word(0, 5);
    load_word(1, 5);
    pulse_start(2);
    send_word(5, 1'b0);
    send_word(5, 1'b1);
    ch.out_valid = 1'b1; ch.out_data = W'(5);
    check("drain out_ready", int'(ch.out_ready), 0);
    tick();
    tick();
    ch.out_valid = 1'b0;
    wait_done("reload");
    check("reload success", int'(success), 1);
    check("reload received", int'(received), 2);

    // Re-arm from DONE: memory write is ignored, start in RUN is ignored.
    load_word(0, 9);
    pulse_start(2);
    check("rearm finished", int'(finished), 0);
    send_word(5, 1'b0);
    pulse_start(0);
    send_word(5, 1'b1);
    wait_done("rearm");
    check("rearm success", int'(success), 1);
    check("rearm received", int'(received), 2);
    check("rearm mismatches", int'(mismatches), 0);

    // FIFO alone: fill past depth without popping, then drain in order.
    do_reset();
    check("fifo rst empty", int'(f_empty), 1);
    for (int k = 0; k < 5; k++) begin
      f_push = 1'b1; f_wdata = word_t'(k + 1);
      tick();
    end
    f_push = 1'b0;
    check("fifo full", int'(f_full), 1);
    f_pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fifo pop%0d", k), int'(f_rdata), k + 1);
      tick();
    end
    f_pop = 1'b0;
    check("fifo drained empty", int'(f_empty), 1);
    f_push = 1'b1; f_pop = 1'b1; f_wdata = word_t'(42);
    tick();
    f_push = 1'b0;
    check("fifo no-bypass empty", int'(f_empty), 0);
    check("fifo no-bypass data", int'(f_rdata), 42);
    tick();
    f_pop = 1'b0;
    check("fifo final empty", int'(f_empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
